rps_opponent: RTL and testbench

Computer opponent for the rock-paper-scissors game. It sits on the far side of the game controller's move interface. When the controller requests a round, it spins through candidate moves driven by a free-running 16-bit LFSR. It freezes on `stop_signal`, or automatically after a timeout, then presents the chosen move and holds it until the controller acknowledges.

---
 rtl/rps_opponent.sv | 128 ++++++++++++
 tb/tb_rps_opponent.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rps_opponent.sv
// Rock-paper-scissors computer opponent: LFSR-driven spin, stop/auto-stop, hold until ack.
// Optional per-move statistics counters are enabled with `define RPS_OPPONENT_STATS_EN.
module rps_opponent #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          SPIN_MIN = 4,
    parameter int          SPIN_MAX = 200
) (
    input  logic       clock,
    input  logic       reset_button,
    input  logic       req,
    input  logic       stop_signal,
    input  logic       ack,
    output logic [1:0] move,
    output logic       move_valid,
    output logic       busy
`ifdef RPS_OPPONENT_STATS_EN
    ,
    output logic [7:0] rock_count,
    output logic [7:0] paper_count,
    output logic [7:0] scissors_count
`endif
);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  MIN_M1   = 8'(SPIN_MIN - 1);
    localparam logic [7:0]  MAX_M1   = 8'(SPIN_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [1:0]  idx;
    logic [1:0]  idx_nxt;
    logic [2:0]  idx_sum;
    logic [7:0]  spin_cnt;
    logic        stop_pend;
    logic        spin_exit;

    always_comb begin
        idx_sum = {1'b0, idx} + 3'd1 + {2'b00, lfsr[0]};
        idx_nxt = (idx_sum >= 3'd3) ? 2'(idx_sum - 3'd3) : idx_sum[1:0];
        spin_exit = (((stop_pend | stop_signal) && (spin_cnt >= MIN_M1)) ||
                     (spin_cnt == MAX_M1));
    end

    always_ff @(posedge clock or posedge reset_button) begin
        if (reset_button)
            lfsr <= SEED_EFF;
        else
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clock or posedge reset_button) begin
        if (reset_button) begin
            state      <= IDLE;
            idx        <= 2'd0;
            spin_cnt   <= 8'd0;
            stop_pend  <= 1'b0;
            move       <= 2'b00;
            move_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= SPIN;
                        idx      <= 2'd0;
                        spin_cnt <= 8'd0;
                        busy     <= 1'b1;
                    end
                end
                SPIN: begin
                    idx <= idx_nxt;
                    if (spin_cnt != 8'hFF)
                        spin_cnt <= spin_cnt + 8'd1;
                    if (stop_signal)
                        stop_pend <= 1'b1;
                    if (spin_exit) begin
                        state      <= HOLD;
                        move       <= idx_nxt + 2'd1;
                        move_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        state      <= IDLE;
                        move       <= 2'b00;
                        move_valid <= 1'b0;
                        busy       <= 1'b0;
                        stop_pend  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    move       <= 2'b00;
                    move_valid <= 1'b0;
                    busy       <= 1'b0;
                    stop_pend  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RPS_OPPONENT_STATS_EN
    logic round_done;
    assign round_done = (state == SPIN) && spin_exit;

    always_ff @(posedge clock or posedge reset_button) begin
        if (reset_button) begin
            rock_count     <= 8'd0;
            paper_count    <= 8'd0;
            scissors_count <= 8'd0;
        end else if (round_done) begin
            case (idx_nxt)
                2'd0:    if (rock_count != 8'hFF)     rock_count     <= rock_count + 8'd1;
                2'd1:    if (paper_count != 8'hFF)    paper_count    <= paper_count + 8'd1;
                default: if (scissors_count != 8'hFF) scissors_count <= scissors_count + 8'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rps_opponent.sv
// Scoreboarded randomized bench for rps_opponent; expected moves come from the LFSR bit stream.
module tb_rps_opponent;
    localparam int SPIN_MIN = 4;
    localparam int SPIN_MAX = 200;
    localparam int SEQ_N    = 40000;

    logic       clock = 1'b0;
    logic       reset_button;
    logic       req;
    logic       stop_signal;
    logic       ack;
    logic [1:0] move;
    logic       move_valid;
    logic       busy;
`ifdef RPS_OPPONENT_STATS_EN
    logic [7:0] rock_count;
    logic [7:0] paper_count;
    logic [7:0] scissors_count;
`endif

    rps_opponent #(.SEED(16'hACE1), .SPIN_MIN(SPIN_MIN), .SPIN_MAX(SPIN_MAX)) dut (
        .clock(clock),
        .reset_button(reset_button),
        .req(req),
        .stop_signal(stop_signal),
        .ack(ack),
        .move(move),
        .move_valid(move_valid),
        .busy(busy)
`ifdef RPS_OPPONENT_STATS_EN
        ,
        .rock_count(rock_count),
        .paper_count(paper_count),
        .scissors_count(scissors_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] mv;
        int         edge_idx;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        got;
    logic [15:0] lfsr_seq[SEQ_N];
    int          model_cnt[3];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ecnt;
    logic        prev_v;

    // Index of the next rising edge, counted from reset release.
    always @(posedge clock or posedge reset_button)
        if (reset_button) ecnt <= 0;
        else              ecnt <= ecnt + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Each spin edge k advances the candidate by 1 + (lfsr bit 0 at edge k), modulo 3.
    function automatic logic [1:0] ref_move(input int n, input int e);
        int s = 0;
        for (int k = n + 1; k <= e; k++) s += 1 + int'(lfsr_seq[k][0]);
        return 2'((s % 3) + 1);
    endfunction

    always @(negedge clock) begin
        if (reset_button) prev_v = 1'b0;
        else begin
            if (move_valid && !prev_v) begin
                if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
                else begin
                    got = exp_q.pop_front();
                    check("move", int'(move), int'(got.mv));
                    check("valid_edge", ecnt - 1, got.edge_idx);
                end
            end
            prev_v = move_valid;
        end
    end

    // Caller is at a negedge with the DUT idle. stop_off < 0 means no stop; 0 puts it in IDLE.
    task automatic do_round(input int stop_off, input int hold_n, input bit keep_req);
        int n, s, e, c;
        logic [1:0] mv;
        exp_t x;
        req = 1'b1; stop_signal = 1'b0; ack = 1'b0;
        n = ecnt;
        s = (stop_off < 0) ? -1 : n + stop_off;
        if (s >= n + 1 && s <= n + SPIN_MAX) e = (s > n + SPIN_MIN) ? s : n + SPIN_MIN;
        else                                 e = n + SPIN_MAX;
        if (e + 2 >= SEQ_N) begin
            $display("FAIL seq_range: got %0d expected below %0d", e + 2, SEQ_N);
            $fatal(1, "reference sequence exhausted");
        end
        mv = ref_move(n, e);
        x.mv = mv; x.edge_idx = e;
        exp_q.push_back(x);
        c = int'(mv) - 1;
        if (model_cnt[c] < 255) model_cnt[c]++;
        if (s == n) stop_signal = 1'b1;
        forever begin
            @(negedge clock);
            if (ecnt > e) break;
            check("spin_outputs", int'({busy, move_valid, move}), 4'b1000);
            req = keep_req | ($urandom_range(0, 3) == 0);
            stop_signal = (ecnt == s);
        end
        stop_signal = 1'b0;
        for (int i = 0; i < hold_n; i++) begin
            check("hold_outputs", int'({busy, move_valid, move}), int'({2'b11, mv}));
            req = keep_req | $urandom_range(0, 1);
            stop_signal = $urandom_range(0, 1);
            @(negedge clock);
        end
        check("hold_outputs", int'({busy, move_valid, move}), int'({2'b11, mv}));
        ack = 1'b1;
        stop_signal = 1'b0;
        req = keep_req | $urandom_range(0, 1);
        @(negedge clock);
        ack = 1'b0;
        req = keep_req;
        check("after_ack", int'({busy, move_valid, move}), 0);
    endtask

    initial begin
        reset_button = 1'b1; req = 1'b0; stop_signal = 1'b0; ack = 1'b0;
        lfsr_seq[0] = 16'hACE1;
        for (int i = 1; i < SEQ_N; i++)
            lfsr_seq[i] = (lfsr_seq[i-1] >> 1) ^ (lfsr_seq[i-1][0] ? 16'hB400 : 16'h0000);
        for (int i = 0; i < 3; i++) model_cnt[i] = 0;
        repeat (3) @(negedge clock);
        check("reset_outputs", int'({busy, move_valid, move}), 0);
        reset_button = 1'b0;

        do_round(1, 3, 1'b0);          // early stop: valid SPIN_MIN edges after req
        do_round(-1, 1, 1'b0);         // auto-stop
        do_round(0, 2, 1'b0);          // stop only in IDLE does not preload
        do_round($urandom_range(1, 10), 50, 1'b0);
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(0, 4)) begin
                stop_signal = $urandom_range(0, 1);
                ack = $urandom_range(0, 1);
                @(negedge clock);
            end
            stop_signal = 1'b0; ack = 1'b0;
            do_round($urandom_range(1, 30), $urandom_range(0, 5), 1'b0);
        end

        // Asynchronous reset in the middle of a spin.
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        repeat (5) @(negedge clock);
        check("busy_before_reset", int'(busy), 1);
        #2 reset_button = 1'b1;
        #1 check("async_reset_outputs", int'({busy, move_valid, move}), 0);
        @(negedge clock);
        check("reset_held_outputs", int'({busy, move_valid, move}), 0);
        reset_button = 1'b0;
        for (int i = 0; i < 3; i++) model_cnt[i] = 0;
        do_round(2, 1, 1'b0);          // LFSR restarted from the seed

        for (int r = 0; r < 30; r++)
            do_round(($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 40)), 0, 1'b1);
        req = 1'b0;

        for (int r = 0; r < 800; r++)
            do_round($urandom_range(1, 3), 0, 1'b1);
        req = 1'b0;
        @(negedge clock);
`ifdef RPS_OPPONENT_STATS_EN
        check("rock_count", int'(rock_count), model_cnt[0]);
        check("paper_count", int'(paper_count), model_cnt[1]);
        check("scissors_count", int'(scissors_count), model_cnt[2]);
`endif
        repeat (3) @(negedge clock);
        check("idle_at_end", int'({busy, move_valid, move}), 0);
        check("pending_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
